// File: rtl/lz77_enc_arbiter_if.sv
// ============================================================================
// Module : lz77_enc_arbiter_if
// Brief  : Source/encoder handshake and status bundle for lz77_enc_arbiter.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface lz77_enc_arbiter_if #(
  parameter int CNT_W = 13
);
  logic             s0_valid;
  logic [7:0]       s0_data;
  logic             s0_last;
  logic             s0_ready;
  logic             s1_valid;
  logic [7:0]       s1_data;
  logic             s1_last;
  logic             s1_ready;
  logic             enc_rdy;
  logic             enc_finish;
  logic             enc_en;
  logic [7:0]       enc_data;
  logic             grant;
  logic             busy;
  logic [CNT_W-1:0] byte_cnt;
  logic             blk_done;
  logic             err;

  // Arbiter side
  modport slave (
    input  s0_valid, s0_data, s0_last, s1_valid, s1_data, s1_last,
    input  enc_rdy, enc_finish,
    output s0_ready, s1_ready, enc_en, enc_data,
    output grant, busy, byte_cnt, blk_done, err
  );

  // Sources/encoder/observer side
  modport master (
    output s0_valid, s0_data, s0_last, s1_valid, s1_data, s1_last,
    output enc_rdy, enc_finish,
    input  s0_ready, s1_ready, enc_en, enc_data,
    input  grant, busy, byte_cnt, blk_done, err
  );
endinterface

`default_nettype wire

// File: rtl/lz77_enc_arbiter.sv
// ============================================================================
// Module : lz77_enc_arbiter
// Brief  : Block-granular round-robin share of one LZ77 encoder by two sources.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module lz77_enc_arbiter #(
  parameter int BLK_LEN = 4096,
  parameter int CNT_W   = 13
) (
  input  wire logic          clk,
  input  wire logic          rst,
  lz77_enc_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] c_LAST_CNT = CNT_W'(BLK_LEN - 1);
  localparam logic [CNT_W-1:0] c_ONE      = CNT_W'(1);

  state_t           r_state;
  logic             r_grant;
  logic             r_prio;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_done;
  logic             r_err;

  logic             w_sel_valid;
  logic [7:0]       w_sel_data;
  logic             w_sel_last;
  logic             w_stream;
  logic             w_beat;
  logic             w_close;

  always_comb begin
    w_sel_valid = r_grant ? bus.s1_valid : bus.s0_valid;
    w_sel_data  = r_grant ? bus.s1_data  : bus.s0_data;
    w_sel_last  = r_grant ? bus.s1_last  : bus.s0_last;
    w_stream    = (r_state == STREAM);
    w_beat      = w_stream && w_sel_valid && bus.enc_rdy;
    // Forced close keeps the counter from ever reaching past BLK_LEN
    w_close     = w_sel_last || (r_cnt == c_LAST_CNT);
  end

  assign bus.s0_ready = w_stream && !r_grant && bus.enc_rdy;
  assign bus.s1_ready = w_stream &&  r_grant && bus.enc_rdy;
  assign bus.enc_en   = w_beat;
  assign bus.enc_data = w_beat ? w_sel_data : 8'h00;
  assign bus.grant    = r_grant;
  assign bus.busy     = r_busy;
  assign bus.byte_cnt = r_cnt;
  assign bus.blk_done = r_done;
  assign bus.err      = r_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_grant <= 1'b0;
      r_prio  <= 1'b0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      // A finish outside DRAIN is a protocol violation; it never closes a block
      if (bus.enc_finish && (r_state != DRAIN)) begin
        r_err <= 1'b1;
      end
      case (r_state)
        IDLE: begin
          if (bus.s0_valid || bus.s1_valid) begin
            r_grant <= (bus.s0_valid && bus.s1_valid) ? r_prio : bus.s1_valid;
            r_state <= STREAM;
            r_busy  <= 1'b1;
          end
        end
        STREAM: begin
          if (w_beat) begin
            r_cnt <= r_cnt + c_ONE;
            if (w_close) begin
              r_state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (bus.enc_finish) begin
            r_done  <= 1'b1;
            r_cnt   <= '0;
            r_prio  <= ~r_grant;
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
